// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the seven-segment display path.
//   SSD_DIGITS / SSD_DATA_W : geometry of the 8-digit, 32-bit display word.
//   disp_state_t            : capture/hold state of the source controller.
//   cnt_w()                 : counter width helper that never returns zero.
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int SSD_DIGITS = 8;
  localparam int SSD_DATA_W = 32;

  typedef enum logic {
    DS_WAIT,
    DS_HOLD
  } disp_state_t;

  // Width of a counter that runs 0..limit-1; a limit of 1 still needs one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/display_src_ctrl_zero_blank_mask.sv
// -----------------------------------------------------------------------------
// zero_blank_mask
// Combinational leading-zero blanking mask for an 8-digit hex display.
//   word : 32-bit displayed value, nibble 7 is the leftmost digit.
//   mask : bit i set iff any nibble j >= i is nonzero; bit 0 always set so
//          a zero word still shows a single "0".
// Only instantiated when DISPLAY_SRC_CTRL_BLANK_EN is defined.
// -----------------------------------------------------------------------------
module zero_blank_mask
  import display_pkg::*;
(
  input  logic [SSD_DATA_W-1:0] word,
  output logic [SSD_DIGITS-1:0] mask
);

  logic seen;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    seen = 1'b0;
    mask = '0;
    // Scan from the leftmost digit; once a nonzero nibble is seen, every
    // digit to its right stays lit.
    for (int i = SSD_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (|word[4*i +: 4]);
      mask[i] = seen;
    end
    mask[0] = 1'b1;
  end

endmodule

// File: rtl/display_src_ctrl.sv
// -----------------------------------------------------------------------------
// display_src_ctrl
// Shares the 8-digit seven-segment display among NUM_SRC 32-bit debug sources.
// The selected source is captured through a valid/ack handshake, re-sampled
// every REFRESH_CYCLES cycles, and the selection advances on a rising edge of
// next_btn or, with auto_en, after ROTATE_REFRESHES completed refreshes.
//
// Ports:
//   clk, nrst  : clock, synchronous active-low reset
//   src_data   : NUM_SRC packed 32-bit words, source k at [32k+31:32k]
//   src_valid  : per-source word available
//   src_ack    : one-cycle capture acknowledge (one-hot or zero)
//   next_btn   : synchronised button level, rising edge = next source
//   auto_en    : enable auto-rotation
//   freeze     : hold all state; no capture, counting or advance
//   seq_out    : displayed word, nibble 7 = leftmost digit
//   digit_en   : per-digit enable
//   sel_out    : selected source index
//
// Build option: define DISPLAY_SRC_CTRL_BLANK_EN for leading-zero blanking;
// otherwise digit_en is the constant 8'hFF.
// -----------------------------------------------------------------------------
module display_src_ctrl
  import display_pkg::*;
#(
  parameter int NUM_SRC          = 4,
  parameter int REFRESH_CYCLES   = 1000,
  parameter int ROTATE_REFRESHES = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [SSD_DATA_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ack,
  input  logic                          next_btn,
  input  logic                          auto_en,
  input  logic                          freeze,
  output logic [SSD_DATA_W-1:0]         seq_out,
  output logic [SSD_DIGITS-1:0]         digit_en,
  output logic [$clog2(NUM_SRC)-1:0]    sel_out
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int RW    = cnt_w(REFRESH_CYCLES);
  localparam int TW    = cnt_w(ROTATE_REFRESHES);

  disp_state_t           state, state_n;
  logic [SEL_W-1:0]      sel_n;
  logic [RW-1:0]         refresh_cnt, refresh_n;
  logic [TW-1:0]         rotate_cnt, rotate_n;
  logic                  btn_q;
  logic                  btn_edge, refresh_done, rotate_expire, advance, capture;
  logic [NUM_SRC-1:0]    ack_n;
  logic [SSD_DATA_W-1:0] cur_word;

  assign btn_edge      = next_btn & ~btn_q;
  assign refresh_done  = (state == DS_HOLD) && (refresh_cnt == RW'(REFRESH_CYCLES - 1));
  // The final refresh of a rotation period becomes an advance instead.
  assign rotate_expire = refresh_done && auto_en && (rotate_cnt == TW'(ROTATE_REFRESHES - 1));
  assign advance       = (btn_edge | rotate_expire) & ~freeze;
  assign cur_word      = src_data[SSD_DATA_W*int'(sel_out) +: SSD_DATA_W];

  // Next-state logic: an advance beats both capture and refresh.
  always_comb begin
    state_n   = state;
    sel_n     = sel_out;
    refresh_n = refresh_cnt;
    rotate_n  = rotate_cnt;
    if (!freeze) begin
      if (advance) begin
        sel_n     = (sel_out == SEL_W'(NUM_SRC - 1)) ? '0 : sel_out + 1'b1;
        state_n   = DS_WAIT;
        refresh_n = '0;
        rotate_n  = '0;
      end else begin
        if (!auto_en) rotate_n = '0;
        case (state)
          DS_WAIT: if (src_valid[sel_out]) state_n = DS_HOLD;
          DS_HOLD: begin
            if (refresh_done) begin
              refresh_n = '0;
              state_n   = DS_WAIT;
              if (auto_en) rotate_n = rotate_cnt + 1'b1;
            end else begin
              refresh_n = refresh_cnt + 1'b1;
            end
          end
          default: state_n = DS_WAIT;
        endcase
      end
    end
  end

  // Output decode: capture strobe and the ack value registered alongside it.
  always_comb begin
    capture = !freeze && !advance && (state == DS_WAIT) && src_valid[sel_out];
    ack_n   = capture ? (NUM_SRC'(1) << sel_out) : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nrst) begin
      state       <= DS_WAIT;
      sel_out     <= '0;
      refresh_cnt <= '0;
      rotate_cnt  <= '0;
      btn_q       <= 1'b0;
      src_ack     <= '0;
      seq_out     <= '0;
    end else begin
      // The button history tracks the level even when frozen, so edges
      // arriving during freeze are consumed and lost.
      btn_q       <= next_btn;
      state       <= state_n;
      sel_out     <= sel_n;
      refresh_cnt <= refresh_n;
      rotate_cnt  <= rotate_n;
      src_ack     <= ack_n;
      if (capture) seq_out <= cur_word;
    end
  end

`ifdef DISPLAY_SRC_CTRL_BLANK_EN
  logic [SSD_DIGITS-1:0] mask_n;

  zero_blank_mask u_mask (
    .word (cur_word),
    .mask (mask_n)
  );

  always_ff @(posedge clk) begin
    if (!nrst)        digit_en <= 8'h01;
    else if (capture) digit_en <= mask_n;
  end
`else
  assign digit_en = 8'hFF;
`endif

endmodule
